// File: rtl/pll_sup_pkg.sv
// Shared state encoding and counter sizing for the PLL lock supervisor.
// Declarations only: no logic, no latency, no flow control.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_t;

  // The shared down-counter holds at most (largest timing parameter - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level signal.
// Latency 2 clk edges; no flow control.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: qualifies lock, retries on timeout, releases domain resets staggered.
// All outputs registered (1 cycle after condition, lock seen 2 cycles late); no flow control.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYCLES    = 256,
  parameter int NUM_RST_OUT      = 4,
  parameter int RST_STAGGER      = 32,
  parameter int MAX_RETRY        = 3
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             pll_lock_i,
  input  logic                             restart_i,
  output logic                             pll_rst_o,
  output logic [NUM_RST_OUT-1:0]           dom_rst_n_o,
  output logic                             ready_o,
  output logic                             fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o,
  output logic [7:0]                       lol_cnt_o,
  output logic [2:0]                       state_o
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYC, STABLE_CYCLES, RST_STAGGER);
  localparam int RW = $clog2(MAX_RETRY+1);

  localparam logic [CW-1:0] RST_LOAD   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD    = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LOAD   = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STG_LOAD   = CW'(RST_STAGGER - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  pll_state_t            state;
  logic [CW-1:0]         cnt;
  logic                  lock_s;
  logic [NUM_RST_OUT-1:0] dom_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  // Releases fill from bit 0 upward, so the next pattern is a shift-in of a one.
  always_comb begin
    dom_nxt = (dom_rst_n_o << 1) | NUM_RST_OUT'(1);
  end

  assign state_o = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_RESET_PLL;
      cnt         <= RST_LOAD;
      retry_cnt_o <= '0;
      lol_cnt_o   <= '0;
      pll_rst_o   <= 1'b1;
      dom_rst_n_o <= '0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else if (restart_i) begin
      state       <= ST_RESET_PLL;
      cnt         <= RST_LOAD;
      retry_cnt_o <= '0;
      pll_rst_o   <= 1'b1;
      dom_rst_n_o <= '0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == '0) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= TO_LOAD;
            pll_rst_o <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // Lock is tested before the timeout so a simultaneous lock never costs a retry.
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= STB_LOAD;
          end else if (cnt == '0) begin
            retry_cnt_o <= retry_cnt_o + RW'(1);
            pll_rst_o   <= 1'b1;
            if (retry_cnt_o == RETRY_LAST) begin
              state  <= ST_FAIL;
              fail_o <= 1'b1;
            end else begin
              state <= ST_RESET_PLL;
              cnt   <= RST_LOAD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= TO_LOAD;
          end else if (cnt == '0) begin
            state <= ST_RELEASE;
            cnt   <= STG_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_RELEASE: begin
          if (!lock_s) begin
            state       <= ST_RESET_PLL;
            cnt         <= RST_LOAD;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
          end else if (cnt == '0) begin
            dom_rst_n_o <= dom_nxt;
            cnt         <= STG_LOAD;
            if (&dom_nxt) begin
              state       <= ST_RUN;
              ready_o     <= 1'b1;
              retry_cnt_o <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            if (lol_cnt_o != 8'hFF) lol_cnt_o <= lol_cnt_o + 8'd1;
            state       <= ST_RESET_PLL;
            cnt         <= RST_LOAD;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            ready_o     <= 1'b0;
          end
        end

        ST_FAIL: begin
          pll_rst_o   <= 1'b1;
          dom_rst_n_o <= '0;
          fail_o      <= 1'b1;
        end

        default: begin
          state       <= ST_RESET_PLL;
          cnt         <= RST_LOAD;
          pll_rst_o   <= 1'b1;
          dom_rst_n_o <= '0;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/restart traffic,
// with every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int P  = 4;
  localparam int TO = 100;
  localparam int S  = 8;
  localparam int N  = 3;
  localparam int R  = 4;
  localparam int MR = 2;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic [N-1:0] dom_rst_n_o;
  logic       ready_o;
  logic       fail_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] lol_cnt_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES   (P),
    .LOCK_TIMEOUT_CYC (TO),
    .STABLE_CYCLES    (S),
    .NUM_RST_OUT      (N),
    .RST_STAGGER      (R),
    .MAX_RETRY        (MR)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pll_lock_i  (pll_lock_i),
    .restart_i   (restart_i),
    .pll_rst_o   (pll_rst_o),
    .dom_rst_n_o (dom_rst_n_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .retry_cnt_o (retry_cnt_o),
    .lol_cnt_o   (lol_cnt_o),
    .state_o     (state_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: phase number plus cycles elapsed in that phase.
  int m_ph = 0, m_t = 0, m_retry = 0, m_lol = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  initial begin
    logic ls;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_ph = 0; m_t = 0; m_retry = 0; m_lol = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock_i;
        if (restart_i) begin
          m_ph = 0; m_t = 0; m_retry = 0;
        end else begin
          case (m_ph)
            0: if (m_t == P-1) begin m_ph = 1; m_t = 0; end else m_t++;
            1: if (ls) begin m_ph = 2; m_t = 0; end
               else if (m_t == TO-1) begin
                 m_retry++; m_t = 0;
                 m_ph = (m_retry == MR) ? 5 : 0;
               end else m_t++;
            2: if (!ls) begin m_ph = 1; m_t = 0; end
               else if (m_t == S-1) begin m_ph = 3; m_t = 0; end
               else m_t++;
            3: if (!ls) begin m_ph = 0; m_t = 0; end
               else begin
                 m_t++;
                 if (m_t == R*N) begin m_ph = 4; m_retry = 0; end
               end
            4: if (!ls) begin
                 if (m_lol < 255) m_lol++;
                 m_ph = 0; m_t = 0;
               end
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [18:0] exp_vec();
    logic [N-1:0] d;
    if (m_ph == 4)      d = {N{1'b1}};
    else if (m_ph == 3) d = N'((1 << (m_t / R)) - 1);
    else                d = '0;
    return {3'(m_ph), (m_ph == 0 || m_ph == 5), d, (m_ph == 4), (m_ph == 5),
            2'(m_retry), 8'(m_lol)};
  endfunction

  wire [18:0] dut_vec = {state_o, pll_rst_o, dom_rst_n_o, ready_o, fail_o, retry_cnt_o, lol_cnt_o};

  always @(negedge sys_clk) begin
    if (chk_en) check_eq("outs", 32'(dut_vec), 32'(exp_vec()));
  end

  function automatic int obs(input int sel);
    case (sel)
      0: return int'(state_o);
      1: return int'(ready_o);
      2: return int'(fail_o);
      3: return int'(dom_rst_n_o);
      4: return int'(retry_cnt_o);
      6: return int'(state_o == 3'd1 && retry_cnt_o == 2'd1);
      default: return int'(pll_rst_o);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int val, input int maxc);
    int n;
    n = 0;
    while (obs(sel) != val && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, 32'(obs(sel) == val), 32'd1);
  endtask

  // Counts negedge samples of one pll_rst_o high period, starting with the current sample.
  task automatic pulse_width(output int w);
    int n;
    n = 0; w = 0;
    while (pll_rst_o !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
    while (pll_rst_o === 1'b1 && w < 400) begin w++; @(negedge sys_clk); end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_state"}, 32'(state_o), 32'd0);
    check_eq({pfx, "_pll_rst"}, 32'(pll_rst_o), 32'd1);
    check_eq({pfx, "_dom"}, 32'(dom_rst_n_o), 32'd0);
    check_eq({pfx, "_ready"}, 32'(ready_o), 32'd0);
    check_eq({pfx, "_fail"}, 32'(fail_o), 32'd0);
    check_eq({pfx, "_retry"}, 32'(retry_cnt_o), 32'd0);
    check_eq({pfx, "_lol"}, 32'(lol_cnt_o), 32'd0);
  endtask

  initial begin
    int w, n;
    logic saw_wait;
    sys_rst_n = 1'b1; pll_lock_i = 1'b0; restart_i = 1'b0;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("rst");
    chk_en = 1'b1;

    // Clean lock
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    pulse_width(w);
    check_eq("rst_pulse", 32'(w), 32'(P));
    repeat (15) @(negedge sys_clk);
    pll_lock_i = 1'b1;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (dom_rst_n_o[0] !== 1'b1 && n < 200);
    check_eq("rel_latency", 32'(n - 1), 32'(2 + S + R));
    check_eq("dom_001", 32'(dom_rst_n_o), 32'b001);
    repeat (R) @(negedge sys_clk);
    check_eq("dom_011", 32'(dom_rst_n_o), 32'b011);
    repeat (R) @(negedge sys_clk);
    check_eq("dom_111", 32'(dom_rst_n_o), 32'b111);
    check_eq("ready", 32'(ready_o), 32'd1);
    check_eq("retry_clean", 32'(retry_cnt_o), 32'd0);

    // Loss of lock in RUN, repeated past saturation
    for (int i = 0; i < 300; i++) begin
      pll_lock_i = 1'b0;
      n = 0;
      do begin @(negedge sys_clk); n++; end
      while (!(dom_rst_n_o == '0 && ready_o == 1'b0) && n < 20);
      check_eq("lol_latency", 32'(n), 32'd3);
      check_eq("lol_cnt", 32'(lol_cnt_o), 32'((i + 1 > 255) ? 255 : i + 1));
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      pll_lock_i = 1'b1;
      wait_for("relock_ready", 1, 1, 400);
    end
    check_eq("lol_sat", 32'(lol_cnt_o), 32'd255);

    // Timeout then lock in attempt 2
    pll_lock_i = 1'b0; restart_i = 1'b1;
    @(negedge sys_clk); restart_i = 1'b0;
    pulse_width(w);
    check_eq("try1_pulse", 32'(w), 32'(P));
    pulse_width(w);
    check_eq("try2_pulse", 32'(w), 32'(P));
    check_eq("retry_one", 32'(retry_cnt_o), 32'd1);
    check_eq("lol_kept", 32'(lol_cnt_o), 32'd255);
    pll_lock_i = 1'b1;
    wait_for("retry_ready", 1, 1, 400);
    check_eq("retry_cleared", 32'(retry_cnt_o), 32'd0);

    // Lock never arrives
    pll_lock_i = 1'b0; restart_i = 1'b1;
    @(negedge sys_clk); restart_i = 1'b0;
    wait_for("reach_fail", 2, 1, 1000);
    check_eq("fail_state", 32'(state_o), 32'd5);
    check_eq("fail_pll_rst", 32'(pll_rst_o), 32'd1);
    check_eq("fail_retry", 32'(retry_cnt_o), 32'(MR));
    repeat (10) @(negedge sys_clk);
    check_eq("fail_sticky", 32'(fail_o), 32'd1);
    restart_i = 1'b1;
    @(negedge sys_clk); restart_i = 1'b0;
    check_eq("restart_fail_clr", 32'(fail_o), 32'd0);
    check_eq("restart_state", 32'(state_o), 32'd0);
    pulse_width(w);
    check_eq("restart_pulse", 32'(w), 32'(P));

    // restart_i in the same cycle as the second timeout
    wait_for("try2_wait", 6, 1, 400);
    repeat (TO - 1) @(negedge sys_clk);
    restart_i = 1'b1;
    @(negedge sys_clk); restart_i = 1'b0;
    check_eq("prio_state", 32'(state_o), 32'd0);
    check_eq("prio_retry", 32'(retry_cnt_o), 32'd0);
    check_eq("prio_fail", 32'(fail_o), 32'd0);

    // One-cycle glitch during STABLE
    pll_lock_i = 1'b1;
    wait_for("reach_stable", 0, 2, 100);
    repeat (4) @(negedge sys_clk);
    pll_lock_i = 1'b0;
    @(negedge sys_clk);
    pll_lock_i = 1'b1;
    n = 0; saw_wait = 1'b0;
    do begin
      @(negedge sys_clk); n++;
      if (state_o == 3'd1) saw_wait = 1'b1;
    end while (dom_rst_n_o[0] !== 1'b1 && n < 200);
    check_eq("glitch_wait", 32'(saw_wait), 32'd1);
    check_eq("glitch_requal", 32'(n - 1), 32'(2 + S + R));

    // Asynchronous reset in the middle of RELEASE
    repeat (2) @(negedge sys_clk);
    check_eq("in_release", 32'(state_o), 32'd3);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_vals("arst");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Random lock activity with occasional restarts
    for (int seg = 0; seg < 150; seg++) begin
      int dur;
      pll_lock_i = ($urandom_range(0, 3) != 0);
      dur = pll_lock_i ? $urandom_range(1, 40) : $urandom_range(1, 250);
      for (int c = 0; c < dur; c++) begin
        restart_i = ($urandom_range(0, 63) == 0);
        @(negedge sys_clk);
      end
      restart_i = 1'b0;
    end

    @(negedge sys_clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencer that sits beside a PLL instance: drives the PLL reset, supervises its lock output, retries when lock is not reached, and releases a parametrised set of downstream domain resets in staggered order once lock is stable. Generalises the fixed single-output PLL wrapper, which has reset and power-down tied off and reports lock raw: it adds lock qualification, timeout/retry, loss-of-lock recovery and N sequenced reset outputs. Runs on the PLL reference clock, which is always present.

## Interface
- PLL_RST_CYCLES, 16: cycles pll_rst_o is held high per PLL reset attempt (≥1)
- LOCK_TIMEOUT_CYC, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz)
- STABLE_CYCLES, 256: consecutive synchronised lock-high cycles required before release
- NUM_RST_OUT, 4: number of domain reset outputs (1..16)
- RST_STAGGER, 32: cycles between successive domain reset releases (≥1)
- MAX_RETRY, 3: failed lock attempts before FAIL (≥1)

- sys_clk  in  1  PLL reference clock; the block's only clock
- sys_rst_n  in  1  asynchronous, active-low reset
- pll_lock_i  in  1  PLL lock, asynchronous to sys_clk
- restart_i  in  1  single-cycle request to restart the whole sequence
- pll_rst_o  out  1  PLL reset, active-high
- dom_rst_n_o  out  NUM_RST_OUT  domain resets, active-low; bit 0 released first
- ready_o  out  1  all domain resets released, lock held
- fail_o  out  1  sticky: MAX_RETRY attempts timed out
- retry_cnt_o  out  $clog2(MAX_RETRY+1)  failed attempts in the current sequence
- lol_cnt_o  out  8  saturating count of lock losses in RUN
- state_o  out  3  current state encoding

## Operation
- pll_lock_i passes through a 2-FF synchroniser giving lock_s. All decisions use lock_s only.
- States: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- RESET_PLL: pll_rst_o=1 and all dom_rst_n_o=0. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: timeout counter increments each cycle.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0: retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RESET_PLL.
- STABLE: stable counter increments while lock_s=1.
  - lock_s=0: go to WAIT_LOCK with the timeout counter cleared.
  - STABLE_CYCLES consecutive highs: go to RELEASE.
- RELEASE: bit k of dom_rst_n_o rises RST_STAGGER*(k+1) cycles after entry. After the last bit rises, go to RUN.
  - lock_s=0 at any point: all bits return to 0 and the FSM goes to RESET_PLL.
- RUN: ready_o=1 and retry_cnt is cleared on entry.
  - lock_s=0: lol_cnt increments (saturates at 255), all dom_rst_n_o drop to 0, ready_o drops, and the FSM goes to RESET_PLL.
- FAIL: pll_rst_o=1, dom_rst_n_o all 0, fail_o=1. The only exits are restart_i or sys_rst_n.
- restart_i: from any state, go to RESET_PLL. This clears retry_cnt, fail_o and all counters except lol_cnt. restart_i has priority over every other transition in the same cycle.
- Timeout and lock_s rising in the same cycle: lock wins, the FSM goes to STABLE and there is no retry.

## Timing
- Reset values while sys_rst_n=0 (asynchronous): state RESET_PLL, pll_rst_o=1, dom_rst_n_o=0, ready_o=0, fail_o=0, retry_cnt_o=0, lol_cnt_o=0.
- All outputs are registered. Outputs change 1 cycle after the state or counter condition.
- lock_s lags pll_lock_i by 2 cycles, so:
  - Lock-loss-to-reset-assertion latency is 3 sys_clk edges.
  - Lock-high-to-first-release minimum latency is 2 + STABLE_CYCLES + RST_STAGGER cycles.
- pll_rst_o pulse width is exactly PLL_RST_CYCLES cycles per attempt.
- If sys_rst_n asserts mid-sequence, all state is lost and the sequence restarts from RESET_PLL on deassertion.

## Structure
- Package pll_sup_pkg holds:
  - the state enum and its 3-bit encodings
  - a helper function for counter width, $clog2 of the maximum of the timing parameters
- Sub-module sync_2ff is a 1-bit two-flop synchroniser, reusable elsewhere for async status inputs.
- A single shared down-counter serves RESET_PLL, WAIT_LOCK, STABLE and RELEASE, sized by the helper.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYC=100, STABLE_CYCLES=8, NUM_RST_OUT=3, RST_STAGGER=4, MAX_RETRY=2.
- Clean lock: raise lock 20 cycles after reset release.
  - pll_rst_o is high for 4 cycles.
  - dom_rst_n_o goes 000→001→011→111 at 4-cycle spacing.
  - ready_o=1 and retry_cnt_o=0.
- Timeout/retry: lock first rises in attempt 2. Expect retry_cnt_o=1, a second 4-cycle pll_rst_o pulse, then a normal release.
- Fail: lock never rises.
  - After 2 timeouts: fail_o=1, state_o=5, pll_rst_o=1.
  - A restart_i pulse clears fail_o and starts a new pll_rst_o pulse.
- Glitch during STABLE: drop lock for 1 cycle after 5 stable cycles. Expect a return to WAIT_LOCK, then a full 8-cycle requalification before release.
- Loss in RUN: drop lock. Expect dom_rst_n_o=000 and ready_o=0 within 3 cycles, lol_cnt_o=1, then full re-sequence. Repeat 300 times and check lol_cnt_o saturates at 255.
- Priority and reset: restart_i in the same cycle as a timeout gives RESET_PLL with retry_cnt_o=0. sys_rst_n asserted during RELEASE immediately forces all outputs to their reset values.
